spindash_mixer: RTL and testbench
=================================

SPINDASH_MIXER -- requirements
Module: spindash_mixer

Interface
REQ-001 Parameter YM_COUNT, 7, number of chip inputs mixed (1..31).
REQ-002 Parameter IN_W, 16, signed sample width per chip.
REQ-003 Parameter GAIN_W, 8, unsigned per-chip gain width; unity = 2^(GAIN_W-1).
REQ-004 Parameter OUT_W, 16+$clog2(YM_COUNT) (16 when YM_COUNT=1), signed mix width.
REQ-005 clk_jt  in  1  master clock; all logic on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 snd_sample  in  1  new-sample strobe from chip 0; level, rising edge significant.
REQ-008 snd_left_ic  in  YM_COUNT*IN_W  packed signed left samples, chip i at bits [i*IN_W +: IN_W].
REQ-009 snd_right_ic  in  YM_COUNT*IN_W  packed signed right samples, same packing.
REQ-010 cfg_we  in  1  gain/mute write strobe, one cycle.
REQ-011 cfg_sel  in  5  target chip, 1..YM_COUNT (chip-select numbering).
REQ-012 cfg_gain  in  GAIN_W  gain value written.
REQ-013 cfg_mute  in  1  mute flag written.
REQ-014 mix_left  out  OUT_W  registered saturated left mix.
REQ-015 mix_right  out  OUT_W  registered saturated right mix.
REQ-016 mix_valid  out  1  one-cycle pulse when mix_left/right update.
REQ-017 busy  out  1  high when state is not IDLE.
REQ-018 overrun  out  1  sticky: sample edge arrived while busy.

Function
REQ-019 Edge detect: snd_sample registered into prev; edge = snd_sample & ~prev.
REQ-020 States IDLE, ACCUM, SAT; IDLE->ACCUM on edge; ACCUM->SAT after YM_COUNT cycles; SAT->IDLE after one cycle.
REQ-021 On edge in IDLE: latch all inputs into capture regs, copy shadow gain/mute to active set, clear both accumulators, index=0.
REQ-022 ACCUM: each cycle acc += capture[index]*active_gain[index] (0 if active_mute[index]); index increments; L and R in parallel.
REQ-023 Product signed IN_W x unsigned GAIN_W -> IN_W+GAIN_W+1 bits signed; accumulator IN_W+GAIN_W+1+$clog2(YM_COUNT) bits, no internal overflow.
REQ-024 SAT: arithmetic shift right by GAIN_W-1, clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1], register to mix_left/right, pulse mix_valid.
REQ-025 Latency: mix_valid high in the cycle after the (YM_COUNT+1)th posedge following the capturing edge; one valid per accepted edge.
REQ-026 mix_left/right hold value between valids.
REQ-027 Edge while busy: ignored, overrun set, current mix unaffected; overrun cleared only by rst.
REQ-028 cfg_we with cfg_sel in 1..YM_COUNT writes shadow gain/mute of chip cfg_sel-1; cfg_sel 0 or >YM_COUNT ignored.
REQ-029 cfg_we in same cycle as capture: shadow updates, active receives old shadow; new value applies from next sample.
REQ-030 cfg_we during ACCUM/SAT does not alter the mix in progress.

Reset
REQ-031 rst: state IDLE, mix_left/right 0, mix_valid 0, overrun 0, accumulators 0, index 0.
REQ-032 rst: all shadow and active gains = unity, mutes 0.
REQ-033 rst: prev = 1, so snd_sample held high through reset release is not an edge.
REQ-034 rst mid-ACCUM/SAT: abort, no mix_valid, outputs 0 next cycle.

Structure
REQ-035 Package spindash_pkg holds state enum, unity-gain constant function, accumulator/product width functions.
REQ-036 Sub-module spindash_sat (shift + clamp, combinational, parametrised in/out width), instantiated twice (L/R).

Verification
REQ-037 YM_COUNT=3, unity gains, L={1000,2000,-500} -> mix_left=2500, mix_valid pulse 4 edges after capture, single cycle.
REQ-038 YM_COUNT=1, gain 255, L=32767 -> 32767; L=-32768 -> -32768 (saturated both rails).
REQ-039 YM_COUNT=3, gains {128,64,128}, chip3 muted, L={1000,2000,-500} -> mix_left=2000.
REQ-040 cfg_we chip1 gain 0 same cycle as edge, L={1000,0,0} -> 1000; next sample -> 0.
REQ-041 Second snd_sample edge during ACCUM -> overrun=1 sticky, exactly one mix_valid.
REQ-042 rst asserted mid-ACCUM -> no mix_valid, mix_left/right=0, busy=0, gains unity.

Source files
------------

// File: rtl/spindash_pkg.sv
// Shared types and width helpers for the multi-chip sound mixer.
package spindash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SAT   = 2'd2
  } state_t;

  function automatic int unity_gain(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  // Signed sample times zero-extended unsigned gain.
  function automatic int prod_width(input int in_w, input int gain_w);
    return in_w + gain_w + 1;
  endfunction

  function automatic int acc_width(input int in_w, input int gain_w, input int ym_count);
    return prod_width(in_w, gain_w) + $clog2(ym_count);
  endfunction

endpackage

// File: rtl/spindash_sat.sv
// Drops the gain fraction bits and clamps the accumulator into the output range.
module spindash_sat #(
  parameter int IN_W  = 28,
  parameter int OUT_W = 18,
  parameter int SHIFT = 7
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;

  always_comb begin
    shifted = din >>> SHIFT;
    if (shifted > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
    end else begin
      dout = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/spindash_mixer.sv
// Captures one sample per chip on the chip-0 strobe, then accumulates gained
// samples one chip per cycle and emits a saturated stereo mix.
module spindash_mixer
  import spindash_pkg::*;
#(
  parameter int YM_COUNT = 7,
  parameter int IN_W     = 16,
  parameter int GAIN_W   = 8,
  parameter int OUT_W    = 16 + $clog2(YM_COUNT)
) (
  input  logic                       clk_jt,
  input  logic                       rst,
  input  logic                       snd_sample,
  input  logic [YM_COUNT*IN_W-1:0]   snd_left_ic,
  input  logic [YM_COUNT*IN_W-1:0]   snd_right_ic,
  input  logic                       cfg_we,
  input  logic [4:0]                 cfg_sel,
  input  logic [GAIN_W-1:0]          cfg_gain,
  input  logic                       cfg_mute,
  output logic signed [OUT_W-1:0]    mix_left,
  output logic signed [OUT_W-1:0]    mix_right,
  output logic                       mix_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int PROD_W = prod_width(IN_W, GAIN_W);
  localparam int ACC_W  = acc_width(IN_W, GAIN_W, YM_COUNT);
  localparam int IDX_W  = (YM_COUNT > 1) ? $clog2(YM_COUNT) : 1;
  localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(unity_gain(GAIN_W));
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(YM_COUNT - 1);

  state_t                    state_q, state_d;
  logic                      prev_q, prev_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [OUT_W-1:0]   mix_l_q, mix_l_d, mix_r_q, mix_r_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;

  logic                      edge_det, capture;
  logic signed [IN_W-1:0]    cap_l_arr [YM_COUNT];
  logic signed [IN_W-1:0]    cap_r_arr [YM_COUNT];
  logic [GAIN_W-1:0]         act_gain_arr [YM_COUNT];
  logic                      act_mute_arr [YM_COUNT];

  assign edge_det = snd_sample & ~prev_q;
  assign capture  = edge_det && (state_q == ST_IDLE);

  // Per-chip capture registers plus shadow (host-written) and active (in-use) gain sets.
  for (genvar gi = 0; gi < YM_COUNT; gi++) begin : g_chip
    logic signed [IN_W-1:0] cap_l_q, cap_l_d, cap_r_q, cap_r_d;
    logic [GAIN_W-1:0]      sh_gain_q, sh_gain_d, act_gain_q, act_gain_d;
    logic                   sh_mute_q, sh_mute_d, act_mute_q, act_mute_d;
    logic                   wr_hit;

    assign wr_hit = cfg_we && (cfg_sel == 5'(gi + 1));

    always_comb begin
      cap_l_d    = cap_l_q;
      cap_r_d    = cap_r_q;
      act_gain_d = act_gain_q;
      act_mute_d = act_mute_q;
      if (capture) begin
        cap_l_d    = snd_left_ic[gi*IN_W +: IN_W];
        cap_r_d    = snd_right_ic[gi*IN_W +: IN_W];
        act_gain_d = sh_gain_q;
        act_mute_d = sh_mute_q;
      end
      sh_gain_d = wr_hit ? cfg_gain : sh_gain_q;
      sh_mute_d = wr_hit ? cfg_mute : sh_mute_q;
    end

    always_ff @(posedge clk_jt) begin
      if (rst) begin
        cap_l_q    <= '0;
        cap_r_q    <= '0;
        sh_gain_q  <= UNITY;
        sh_mute_q  <= 1'b0;
        act_gain_q <= UNITY;
        act_mute_q <= 1'b0;
      end else begin
        cap_l_q    <= cap_l_d;
        cap_r_q    <= cap_r_d;
        sh_gain_q  <= sh_gain_d;
        sh_mute_q  <= sh_mute_d;
        act_gain_q <= act_gain_d;
        act_mute_q <= act_mute_d;
      end
    end

    assign cap_l_arr[gi]    = cap_l_q;
    assign cap_r_arr[gi]    = cap_r_q;
    assign act_gain_arr[gi] = act_gain_q;
    assign act_mute_arr[gi] = act_mute_q;
  end

  logic [GAIN_W-1:0]        cur_gain;
  logic signed [PROD_W-1:0] prod_l, prod_r, gain_ext;
  logic signed [OUT_W-1:0]  sat_l, sat_r;

  always_comb begin
    cur_gain = act_gain_arr[idx_q];
    gain_ext = PROD_W'($signed({1'b0, cur_gain}));
    prod_l   = act_mute_arr[idx_q] ? '0 : PROD_W'(cap_l_arr[idx_q]) * gain_ext;
    prod_r   = act_mute_arr[idx_q] ? '0 : PROD_W'(cap_r_arr[idx_q]) * gain_ext;
  end

  spindash_sat #(.IN_W(ACC_W), .OUT_W(OUT_W), .SHIFT(GAIN_W - 1)) u_sat_l (
    .din (acc_l_q),
    .dout(sat_l)
  );

  spindash_sat #(.IN_W(ACC_W), .OUT_W(OUT_W), .SHIFT(GAIN_W - 1)) u_sat_r (
    .din (acc_r_q),
    .dout(sat_r)
  );

  always_comb begin
    state_d   = state_q;
    prev_d    = snd_sample;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    mix_l_d   = mix_l_q;
    mix_r_d   = mix_r_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (edge_det && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (edge_det) begin
          state_d = ST_ACCUM;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
        end
      end
      ST_ACCUM: begin
        acc_l_d = acc_l_q + ACC_W'(prod_l);
        acc_r_d = acc_r_q + ACC_W'(prod_r);
        if (idx_q == LAST_IDX) begin
          state_d = ST_SAT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_SAT: begin
        mix_l_d = sat_l;
        mix_r_d = sat_r;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // prev resets high so a strobe already high at reset release is not an edge.
  always_ff @(posedge clk_jt) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prev_q    <= 1'b1;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      mix_l_q   <= '0;
      mix_r_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      mix_l_q   <= mix_l_d;
      mix_r_q   <= mix_r_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign mix_left  = mix_l_q;
  assign mix_right = mix_r_q;
  assign mix_valid = valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spindash_mixer.sv
// Randomised bench for spindash_mixer against an arithmetic mix model (3-chip and 1-chip builds).
module tb_spindash_mixer;

  localparam int N   = 3;
  localparam int IW  = 16;
  localparam int OW  = 18;
  localparam int OW1 = 16;

  logic clk_jt = 1'b0;
  always #5 clk_jt = ~clk_jt;

  logic               rst, snd_sample, cfg_we, cfg_mute;
  logic [N*IW-1:0]    snd_left_ic, snd_right_ic;
  logic [4:0]         cfg_sel;
  logic [7:0]         cfg_gain;
  logic signed [OW-1:0] mix_left, mix_right;
  logic               mix_valid, busy, overrun;

  logic               s1_sample, s1_cfg_we, s1_cfg_mute;
  logic [IW-1:0]      s1_left, s1_right;
  logic [4:0]         s1_cfg_sel;
  logic [7:0]         s1_cfg_gain;
  logic signed [OW1-1:0] s1_mix_left, s1_mix_right;
  logic               s1_mix_valid, s1_busy, s1_overrun;

  spindash_mixer #(.YM_COUNT(N)) u_dut (
    .clk_jt(clk_jt), .rst(rst), .snd_sample(snd_sample),
    .snd_left_ic(snd_left_ic), .snd_right_ic(snd_right_ic),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_gain(cfg_gain), .cfg_mute(cfg_mute),
    .mix_left(mix_left), .mix_right(mix_right), .mix_valid(mix_valid),
    .busy(busy), .overrun(overrun)
  );

  spindash_mixer #(.YM_COUNT(1)) u_dut1 (
    .clk_jt(clk_jt), .rst(rst), .snd_sample(s1_sample),
    .snd_left_ic(s1_left), .snd_right_ic(s1_right),
    .cfg_we(s1_cfg_we), .cfg_sel(s1_cfg_sel), .cfg_gain(s1_cfg_gain), .cfg_mute(s1_cfg_mute),
    .mix_left(s1_mix_left), .mix_right(s1_mix_right), .mix_valid(s1_mix_valid),
    .busy(s1_busy), .overrun(s1_overrun)
  );

  int checks = 0;
  int failures = 0;
  int sh_gain[N], sh_mute[N], act_gain[N], act_mute[N];

  function automatic longint clamp_shift(input longint sum, input int ow);
    longint hi, lo, v;
    v  = sum >>> 7;
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

  function automatic longint model3(input logic [N*IW-1:0] pk);
    longint sum = 0;
    for (int i = 0; i < N; i++)
      if (act_mute[i] == 0) sum += longint'($signed(pk[i*IW +: IW])) * act_gain[i];
    return clamp_shift(sum, OW);
  endfunction

  function automatic logic [N*IW-1:0] pack3(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      sh_gain[i] = 128; sh_mute[i] = 0; act_gain[i] = 128; act_mute[i] = 0;
    end
  endtask

  task automatic drive_cfg(input logic [4:0] sel, input logic [7:0] g, input logic m);
    cfg_we = 1'b1; cfg_sel = sel; cfg_gain = g; cfg_mute = m;
    if (sel >= 5'd1 && sel <= 5'(N)) begin
      sh_gain[int'(sel) - 1] = int'(g);
      sh_mute[int'(sel) - 1] = int'(m);
    end
  endtask

  task automatic cfg_write(input logic [4:0] sel, input logic [7:0] g, input logic m);
    drive_cfg(sel, g, m);
    @(posedge clk_jt); #1;
    cfg_we = 1'b0;
  endtask

  // cw_at: -1 no write, 0 write with the strobe, k>0 write k cycles after capture.
  task automatic do_sample(input logic [N*IW-1:0] l, input logic [N*IW-1:0] r, input int cw_at,
                           input logic [4:0] cs, input logic [7:0] cg, input logic cm,
                           output int lat, output logic signed [OW-1:0] ml, output logic signed [OW-1:0] mr,
                           output longint el, output longint er, output logic extra);
    for (int i = 0; i < N; i++) begin
      act_gain[i] = sh_gain[i]; act_mute[i] = sh_mute[i];
    end
    el = model3(l);
    er = model3(r);
    snd_left_ic = l; snd_right_ic = r; snd_sample = 1'b1;
    if (cw_at == 0) drive_cfg(cs, cg, cm);
    @(posedge clk_jt); #1;
    snd_sample = 1'b0; cfg_we = 1'b0;
    snd_left_ic  = 48'({$urandom(), $urandom()});
    snd_right_ic = 48'({$urandom(), $urandom()});
    lat = -1; ml = '0; mr = '0;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      if (k == cw_at) drive_cfg(cs, cg, cm);
      @(posedge clk_jt); #1;
      cfg_we = 1'b0;
      if (mix_valid) begin lat = k; ml = mix_left; mr = mix_right; end
    end
    @(posedge clk_jt); #1;
    extra = mix_valid;
    $display("sample l=%h r=%h lat=%0d mix_l=%0d/%0d mix_r=%0d/%0d", l, r, lat, ml, el, mr, er);
  endtask

  task automatic check_mix(input string nm, input int lat, input logic signed [OW-1:0] ml,
                           input logic signed [OW-1:0] mr, input longint el, input longint er, input logic extra);
    checks++; if (lat !== N + 1) begin failures++; $display("FAIL %s latency got=%0d want=%0d", nm, lat, N + 1); end
    checks++; if (longint'(ml) !== el) begin failures++; $display("FAIL %s left got=%0d want=%0d", nm, ml, el); end
    checks++; if (longint'(mr) !== er) begin failures++; $display("FAIL %s right got=%0d want=%0d", nm, mr, er); end
    checks++; if (extra !== 1'b0) begin failures++; $display("FAIL %s valid_width got=%b want=0", nm, extra); end
  endtask

  int lat;
  logic signed [OW-1:0] ml, mr;
  longint el, er;
  logic extra;

  task automatic test_reset();
    int seen = 0;
    checks++; if (mix_left !== '0 || mix_right !== '0) begin failures++; $display("FAIL reset_mix got=%0d,%0d want=0,0", mix_left, mix_right); end
    checks++; if (mix_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b%b want=000", mix_valid, busy, overrun); end
    repeat (5) begin
      @(posedge clk_jt); #1;
      if (busy || mix_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL reset_held_high got=%0d want=0", seen); end
    snd_sample = 1'b0; s1_sample = 1'b0;
    @(posedge clk_jt); #1;
  endtask

  task automatic test_unity();
    do_sample(pack3(1000, 2000, -500), pack3(-7, 300, 12), -1, 0, 0, 0, lat, ml, mr, el, er, extra);
    checks++; if (ml !== 18'sd2500) begin failures++; $display("FAIL unity_left got=%0d want=2500", ml); end
    check_mix("unity", lat, ml, mr, el, er, extra);
  endtask

  task automatic test_gains();
    cfg_write(1, 128, 0); cfg_write(2, 64, 0); cfg_write(3, 128, 1);
    do_sample(pack3(1000, 2000, -500), pack3(4000, -4000, 9999), -1, 0, 0, 0, lat, ml, mr, el, er, extra);
    checks++; if (ml !== 18'sd2000) begin failures++; $display("FAIL gains_left got=%0d want=2000", ml); end
    check_mix("gains", lat, ml, mr, el, er, extra);
  endtask

  task automatic test_cfg_same_cycle();
    cfg_write(1, 128, 0); cfg_write(2, 128, 0); cfg_write(3, 128, 0);
    do_sample(pack3(1000, 0, 0), pack3(500, 0, 0), 0, 1, 0, 0, lat, ml, mr, el, er, extra);
    checks++; if (ml !== 18'sd1000) begin failures++; $display("FAIL cfg_edge_old got=%0d want=1000", ml); end
    check_mix("cfg_edge", lat, ml, mr, el, er, extra);
    do_sample(pack3(1000, 0, 0), pack3(500, 0, 0), -1, 0, 0, 0, lat, ml, mr, el, er, extra);
    checks++; if (ml !== 18'sd0) begin failures++; $display("FAIL cfg_edge_new got=%0d want=0", ml); end
    check_mix("cfg_next", lat, ml, mr, el, er, extra);
  endtask

  task automatic test_cfg_during_accum();
    for (int k = 1; k <= N + 1; k++) begin
      do_sample(pack3(3000, -2000, 1234), pack3(-30000, 30000, 77), k, 5'(k % N + 1), 8'($urandom), 1'($urandom_range(0, 1)),
                lat, ml, mr, el, er, extra);
      check_mix("cfg_busy", lat, ml, mr, el, er, extra);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      repeat (2) cfg_write(5'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 3) == 0));
      do_sample(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), int'($urandom_range(0, 5)) - 1,
                5'($urandom_range(0, 4)), 8'($urandom), 1'($urandom_range(0, 1)), lat, ml, mr, el, er, extra);
      check_mix("random", lat, ml, mr, el, er, extra);
    end
  endtask

  task automatic test_overrun();
    int nvalid = 0;
    longint exp_l, exp_r;
    logic signed [OW-1:0] got_l = '0, got_r = '0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_pre got=%b want=0", overrun); end
    for (int i = 0; i < N; i++) begin act_gain[i] = sh_gain[i]; act_mute[i] = sh_mute[i]; end
    snd_left_ic = pack3(111, 222, 333); snd_right_ic = pack3(-5, 6, -7);
    exp_l = model3(snd_left_ic); exp_r = model3(snd_right_ic);
    snd_sample = 1'b1;
    @(posedge clk_jt); #1; snd_sample = 1'b0;
    @(posedge clk_jt); #1;
    snd_left_ic = pack3(9000, 9000, 9000); snd_right_ic = pack3(9000, 9000, 9000); snd_sample = 1'b1;
    @(posedge clk_jt); #1; snd_sample = 1'b0;
    if (mix_valid) begin nvalid++; got_l = mix_left; got_r = mix_right; end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b want=1", overrun); end
    repeat (12) begin
      @(posedge clk_jt); #1;
      if (mix_valid) begin nvalid++; got_l = mix_left; got_r = mix_right; end
    end
    $display("overrun valids=%0d mix_l=%0d/%0d", nvalid, got_l, exp_l);
    checks++; if (nvalid !== 1) begin failures++; $display("FAIL overrun_valids got=%0d want=1", nvalid); end
    checks++; if (longint'(got_l) !== exp_l || longint'(got_r) !== exp_r) begin failures++; $display("FAIL overrun_mix got=%0d,%0d want=%0d,%0d", got_l, got_r, exp_l, exp_r); end
    do_sample(pack3(10, 20, 30), pack3(1, 2, 3), -1, 0, 0, 0, lat, ml, mr, el, er, extra);
    check_mix("after_overrun", lat, ml, mr, el, er, extra);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
  endtask

  task automatic test_reset_mid();
    int nvalid = 0;
    cfg_write(1, 0, 0); cfg_write(2, 255, 1);
    snd_left_ic = pack3(1000, 2000, -500); snd_right_ic = pack3(1, 1, 1); snd_sample = 1'b1;
    @(posedge clk_jt); #1; snd_sample = 1'b0;
    @(posedge clk_jt); #1;
    rst = 1'b1;
    @(posedge clk_jt); #1;
    rst = 1'b0;
    reset_model();
    checks++; if (mix_left !== '0 || mix_right !== '0) begin failures++; $display("FAIL rst_mid_mix got=%0d,%0d want=0,0", mix_left, mix_right); end
    checks++; if (busy !== 1'b0 || mix_valid !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL rst_mid_flags got=%b%b%b want=000", busy, mix_valid, overrun); end
    repeat (10) begin
      @(posedge clk_jt); #1;
      if (mix_valid) nvalid++;
    end
    checks++; if (nvalid !== 0) begin failures++; $display("FAIL rst_mid_novalid got=%0d want=0", nvalid); end
    do_sample(pack3(1000, 2000, -500), pack3(100, 100, 100), -1, 0, 0, 0, lat, ml, mr, el, er, extra);
    checks++; if (ml !== 18'sd2500) begin failures++; $display("FAIL rst_mid_unity got=%0d want=2500", ml); end
    check_mix("rst_mid", lat, ml, mr, el, er, extra);
  endtask

  task automatic do_sample1(input logic [IW-1:0] l, input logic [IW-1:0] r, output int lat1,
                            output logic signed [OW1-1:0] ml1, output logic signed [OW1-1:0] mr1);
    s1_left = l; s1_right = r; s1_sample = 1'b1;
    @(posedge clk_jt); #1;
    s1_sample = 1'b0; s1_left = 16'($urandom); s1_right = 16'($urandom);
    lat1 = -1; ml1 = '0; mr1 = '0;
    for (int k = 1; k <= 8 && lat1 < 0; k++) begin
      @(posedge clk_jt); #1;
      if (s1_mix_valid) begin lat1 = k; ml1 = s1_mix_left; mr1 = s1_mix_right; end
    end
    @(posedge clk_jt); #1;
    $display("sample1 l=%0d r=%0d lat=%0d mix_l=%0d mix_r=%0d", $signed(l), $signed(r), lat1, ml1, mr1);
  endtask

  task automatic test_sat_single();
    int lat1;
    logic signed [OW1-1:0] ml1, mr1;
    logic [IW-1:0] r;
    s1_cfg_we = 1'b1; s1_cfg_sel = 5'd1; s1_cfg_gain = 8'd255; s1_cfg_mute = 1'b0;
    @(posedge clk_jt); #1; s1_cfg_we = 1'b0;
    r = 16'($urandom);
    do_sample1(16'h7fff, r, lat1, ml1, mr1);
    checks++; if (ml1 !== 16'sd32767) begin failures++; $display("FAIL sat_pos got=%0d want=32767", ml1); end
    checks++; if (lat1 !== 2) begin failures++; $display("FAIL sat_latency got=%0d want=2", lat1); end
    checks++; if (longint'(mr1) !== clamp_shift(longint'($signed(r)) * 255, OW1)) begin failures++; $display("FAIL sat_right got=%0d want=%0d", mr1, clamp_shift(longint'($signed(r)) * 255, OW1)); end
    do_sample1(16'h8000, 16'd100, lat1, ml1, mr1);
    checks++; if (ml1 !== -16'sd32768) begin failures++; $display("FAIL sat_neg got=%0d want=-32768", ml1); end
    checks++; if (mr1 !== 16'sd199) begin failures++; $display("FAIL sat_small got=%0d want=199", mr1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; snd_sample = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_gain = '0; cfg_mute = 1'b0;
    snd_left_ic = '0; snd_right_ic = '0;
    s1_sample = 1'b1; s1_cfg_we = 1'b0; s1_cfg_sel = '0; s1_cfg_gain = '0; s1_cfg_mute = 1'b0;
    s1_left = '0; s1_right = '0;
    reset_model();
    repeat (3) @(posedge clk_jt);
    #1 rst = 1'b0;
    test_reset();
    test_unity();
    test_gains();
    test_cfg_same_cycle();
    test_cfg_during_accum();
    test_random();
    test_sat_single();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
